// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared pipeline widths, reset PC, squash NOP encoding and word-align helper
package if_stage_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int ROM_AW_DEF = 9;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0800_0240;
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction ROM bus (master drives rom_addr, slave returns rom_inst combinationally)
interface if_stage_if #(parameter int AW = if_stage_pkg::ROM_AW_DEF);
  import if_stage_pkg::*;
  logic [AW-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  modport master(output rom_addr, input rom_inst);
  modport slave(input rom_addr, output rom_inst);
endinterface

// File: rtl/if_stage_pc_nreg.sv
// if_stage_pc_nreg: PC/nPC register pair; ports clk,rst,le,redirect,ta in, pc,npc out; rst > redirect > le > hold
module if_stage_pc_nreg
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              le,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] ta,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc
);
  logic [ADDR_W-1:0] tgt;
  assign tgt = word_align(ta);
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + ADDR_W'(4);
    end else if (redirect) begin
      pc  <= tgt;
      npc <= tgt + ADDR_W'(4);
    end else if (le) begin
      pc  <= npc;
      npc <= npc + ADDR_W'(4);
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: fetch stage + IF/ID register; in clk,Reset,LE,BR_TAKEN,TA, rom bus master, out PC_out,nPC_out,ID_inst,ID_PC,ID_valid
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                ROM_AW   = ROM_AW_DEF,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              LE,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] TA,
  if_stage_if.master        rom,
  output logic [ADDR_W-1:0] PC_out,
  output logic [ADDR_W-1:0] nPC_out,
  output logic [INST_W-1:0] ID_inst,
  output logic [ADDR_W-1:0] ID_PC,
  output logic              ID_valid
);
  if_stage_pc_nreg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (Reset),
    .le       (LE),
    .redirect (BR_TAKEN),
    .ta       (TA),
    .pc       (PC_out),
    .npc      (nPC_out)
  );
  assign rom.rom_addr = PC_out[ROM_AW-1:0];
  always_ff @(posedge clk) begin
    if (Reset) begin
      ID_inst  <= '0;
      ID_PC    <= '0;
      ID_valid <= 1'b0;
    end else if (BR_TAKEN) begin
      ID_inst  <= NOP_INST;
      ID_PC    <= PC_out;
      ID_valid <= 1'b0;
    end else if (LE) begin
      ID_inst  <= rom.rom_inst;
      ID_PC    <= PC_out;
      ID_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scoreboard bench for if_stage with a word-equals-address ROM
module tb_if_stage;
  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        LE = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic [31:0] TA = '0;
  logic [31:0] PC_out, nPC_out, ID_inst, ID_PC;
  logic        ID_valid;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [31:0] pc, npc, inst, idpc;
    logic        valid;
  } exp_t;
  exp_t q[$];
  logic [31:0] m_pc = '0, m_npc = 32'h4, m_inst = '0, m_idpc = '0;
  logic        m_valid = 1'b0;
  if_stage_if #(.AW(9)) bus ();
  assign bus.rom_inst = 32'(bus.rom_addr);
  if_stage dut (
    .clk      (clk),
    .Reset    (Reset),
    .LE       (LE),
    .BR_TAKEN (BR_TAKEN),
    .TA       (TA),
    .rom      (bus),
    .PC_out   (PC_out),
    .nPC_out  (nPC_out),
    .ID_inst  (ID_inst),
    .ID_PC    (ID_PC),
    .ID_valid (ID_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic le, input logic br, input logic [31:0] ta);
    exp_t e;
    logic [31:0] t;
    t = {ta[31:2], 2'b00};
    if (r) begin
      m_pc = 32'h0; m_npc = 32'h4; m_inst = '0; m_idpc = '0; m_valid = 1'b0;
    end else if (br) begin
      m_inst = 32'h0800_0240; m_idpc = m_pc; m_valid = 1'b0; m_pc = t; m_npc = t + 32'h4;
    end else if (le) begin
      m_inst = {23'b0, m_pc[8:0]}; m_idpc = m_pc; m_valid = 1'b1; m_pc = m_npc; m_npc = m_npc + 32'h4;
    end
    e = '{pc: m_pc, npc: m_npc, inst: m_inst, idpc: m_idpc, valid: m_valid};
    q.push_back(e);
    Reset = r; LE = le; BR_TAKEN = br; TA = ta;
    #1;
    chk("no_comb_path_pc", PC_out, q.size() > 0 && !r ? PC_out : PC_out);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pc", PC_out, e.pc);
    chk("npc", nPC_out, e.npc);
    chk("id_inst", ID_inst, e.inst);
    chk("id_pc", ID_PC, e.idpc);
    chk("id_valid", 32'(ID_valid), 32'(e.valid));
    chk("rom_addr", 32'(bus.rom_addr), {23'b0, e.pc[8:0]});
  endtask
  initial begin
    logic [31:0] held;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("plan_pc_after4", PC_out, 32'h10);
    chk("plan_idpc_after4", ID_PC, 32'hC);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("plan_stall_pc", PC_out, 32'h8);
    for (int i = 0; i < 3; i++) begin
      held = PC_out;
      Reset = 0; LE = 0; BR_TAKEN = 1; TA = 32'h0000_0EE0;
      #1;
      chk("no_comb_path", PC_out, 32'h8);
      BR_TAKEN = 0;
      step(0, 0, 0, 32'h0000_0EE0);
      chk("stall_pc_hold", PC_out, 32'h8);
    end
    step(0, 1, 0, 0);
    chk("plan_after_stall_pc", PC_out, 32'hC);
    chk("plan_after_stall_idpc", ID_PC, 32'h8);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    chk("plan_pre_branch_pc", PC_out, 32'h20);
    step(0, 1, 1, 32'h103);
    chk("plan_br_pc", PC_out, 32'h100);
    chk("plan_br_npc", nPC_out, 32'h104);
    chk("plan_br_inst", ID_inst, 32'h0800_0240);
    chk("plan_br_valid", 32'(ID_valid), 32'h0);
    step(0, 1, 0, 0);
    chk("plan_post_br_idpc", ID_PC, 32'h100);
    chk("plan_post_br_valid", 32'(ID_valid), 32'h1);
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'h40);
    chk("plan_stall_br_pc", PC_out, 32'h40);
    chk("plan_stall_br_valid", 32'(ID_valid), 32'h0);
    step(0, 0, 1, 32'hFFFF_FFF8);
    step(0, 1, 0, 0);
    chk("plan_wrap_pc1", PC_out, 32'hFFFF_FFFC);
    chk("plan_wrap_npc1", nPC_out, 32'h0);
    step(0, 1, 0, 0);
    chk("plan_wrap_pc2", PC_out, 32'h0);
    chk("plan_wrap_npc2", nPC_out, 32'h4);
    chk("plan_wrap_inst", ID_inst, 32'h1FC);
    step(0, 1, 1, 32'h200);
    chk("plan_pre_reset_pc", PC_out, 32'h200);
    step(1, 1, 1, 32'h80);
    chk("plan_reset_pc", PC_out, 32'h0);
    chk("plan_reset_npc", nPC_out, 32'h4);
    chk("plan_reset_inst", ID_inst, 32'h0);
    chk("plan_reset_valid", 32'(ID_valid), 32'h0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 5) == 0), $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
